axi_lite_xbar: RTL

- 1-master / 3-slave AXI4-Lite crossbar sitting between the core's LSU AXI-Lite master port and the memory-mapped devices: main SRAM, UART, CLINT/RTC.
- Decodes the address and routes each transaction to exactly one slave. Unmapped addresses get a local DECERR response.
- Read and write paths are independent. At most one outstanding transaction per direction.

---
 rtl/axi_lite_if.sv | 37 +++
 rtl/axi_lite_xbar.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle: 32-bit address and data, no IDs, single-beat transfers.
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high; once valid is raised the payload holds
// steady until that edge, and valid never waits on ready.
interface axi_lite_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_xbar.sv
// 1-master / 3-slave AXI4-Lite crossbar (SRAM, UART, CLINT).
// The address is decoded combinationally. Each direction has its own FSM, and
// each FSM allows one transaction in flight. An unmapped address gets a local
// DECERR (2'b11) response.
// Optional macro XBAR_DECERR_FATAL_EN: when it is defined, an AR or AW
// handshake to an unmapped address stops the simulation with $fatal. The
// hardware is the same in both builds.
module axi_lite_xbar #(
    parameter logic [31:0] SRAM_BASE  = 32'h8000_0000,
    parameter logic [31:0] SRAM_SIZE  = 32'h0800_0000,
    parameter logic [31:0] UART_BASE  = 32'ha000_03f8,
    parameter logic [31:0] UART_SIZE  = 32'h8,
    parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
    parameter logic [31:0] CLINT_SIZE = 32'h8
) (
    input  logic       clk,
    input  logic       reset,
    axi_lite_if.slave  m,
    axi_lite_if.master s_sram,
    axi_lite_if.master s_uart,
    axi_lite_if.master s_clint
);

    // Target select encoding. SEL_NONE from the decoder means "unmapped".
    localparam logic [1:0] SEL_NONE  = 2'd0;
    localparam logic [1:0] SEL_SRAM  = 2'd1;
    localparam logic [1:0] SEL_UART  = 2'd2;
    localparam logic [1:0] SEL_CLINT = 2'd3;

    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_DATA = 2'd1;
    localparam logic [1:0] RD_ERR  = 2'd2;

    localparam logic [2:0] WR_IDLE  = 3'd0;
    localparam logic [2:0] WR_DATA  = 3'd1;
    localparam logic [2:0] WR_RESP  = 3'd2;
    localparam logic [2:0] WR_ERR_W = 3'd3;
    localparam logic [2:0] WR_ERR_B = 3'd4;

    logic [1:0] rd_state;
    logic [1:0] rd_sel;
    logic [2:0] wr_state;
    logic [1:0] wr_sel;
    logic [1:0] ar_dec;
    logic [1:0] aw_dec;

    // Compare in 33 bits so that base+size cannot wrap past 2^32.
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return ({1'b0, addr} >= {1'b0, base}) &&
               ({1'b0, addr} < ({1'b0, base} + {1'b0, size}));
    endfunction

    // If regions overlap, SRAM wins over UART, and UART wins over CLINT.
    function automatic logic [1:0] decode(input logic [31:0] addr);
        if (in_region(addr, SRAM_BASE, SRAM_SIZE))
            return SEL_SRAM;
        else if (in_region(addr, UART_BASE, UART_SIZE))
            return SEL_UART;
        else if (in_region(addr, CLINT_BASE, CLINT_SIZE))
            return SEL_CLINT;
        return SEL_NONE;
    endfunction

    assign ar_dec = decode(m.araddr);
    assign aw_dec = decode(m.awaddr);

    // Read routing: AR goes to the decoded slave while idle; R comes back from the latched slave.
    always_comb begin
        s_sram.araddr   = m.araddr;
        s_sram.arprot   = m.arprot;
        s_sram.arvalid  = 1'b0;
        s_sram.rready   = 1'b0;
        s_uart.araddr   = m.araddr;
        s_uart.arprot   = m.arprot;
        s_uart.arvalid  = 1'b0;
        s_uart.rready   = 1'b0;
        s_clint.araddr  = m.araddr;
        s_clint.arprot  = m.arprot;
        s_clint.arvalid = 1'b0;
        s_clint.rready  = 1'b0;
        m.arready       = 1'b0;
        m.rvalid        = 1'b0;
        m.rdata         = 32'h0;
        m.rresp         = 2'b00;
        case (rd_state)
            RD_IDLE: begin
                case (ar_dec)
                    SEL_SRAM:  begin s_sram.arvalid  = m.arvalid; m.arready = s_sram.arready;  end
                    SEL_UART:  begin s_uart.arvalid  = m.arvalid; m.arready = s_uart.arready;  end
                    SEL_CLINT: begin s_clint.arvalid = m.arvalid; m.arready = s_clint.arready; end
                    default:   m.arready = 1'b1;
                endcase
            end
            RD_DATA: begin
                case (rd_sel)
                    SEL_SRAM: begin
                        m.rvalid = s_sram.rvalid; m.rdata = s_sram.rdata;
                        m.rresp = s_sram.rresp; s_sram.rready = m.rready;
                    end
                    SEL_UART: begin
                        m.rvalid = s_uart.rvalid; m.rdata = s_uart.rdata;
                        m.rresp = s_uart.rresp; s_uart.rready = m.rready;
                    end
                    SEL_CLINT: begin
                        m.rvalid = s_clint.rvalid; m.rdata = s_clint.rdata;
                        m.rresp = s_clint.rresp; s_clint.rready = m.rready;
                    end
                    default: ;
                endcase
            end
            RD_ERR: begin
                m.rvalid = 1'b1;
                m.rresp  = 2'b11;
            end
            default: ;
        endcase
    end

    // Read FSM: latch the target on AR and release it on the R handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            rd_sel   <= SEL_NONE;
        end else begin
            case (rd_state)
                RD_IDLE: if (m.arvalid && m.arready) begin
                    rd_sel   <= ar_dec;
                    rd_state <= (ar_dec == SEL_NONE) ? RD_ERR : RD_DATA;
                end
                RD_DATA: if (m.rvalid && m.rready) begin
                    rd_sel   <= SEL_NONE;
                    rd_state <= RD_IDLE;
                end
                RD_ERR: if (m.rready) begin
                    rd_sel   <= SEL_NONE;
                    rd_state <= RD_IDLE;
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Write routing: W is gated until AW has been accepted, so a slave never sees W before AW.
    always_comb begin
        s_sram.awaddr   = m.awaddr;
        s_sram.awprot   = m.awprot;
        s_sram.wdata    = m.wdata;
        s_sram.wstrb    = m.wstrb;
        s_sram.awvalid  = 1'b0;
        s_sram.wvalid   = 1'b0;
        s_sram.bready   = 1'b0;
        s_uart.awaddr   = m.awaddr;
        s_uart.awprot   = m.awprot;
        s_uart.wdata    = m.wdata;
        s_uart.wstrb    = m.wstrb;
        s_uart.awvalid  = 1'b0;
        s_uart.wvalid   = 1'b0;
        s_uart.bready   = 1'b0;
        s_clint.awaddr  = m.awaddr;
        s_clint.awprot  = m.awprot;
        s_clint.wdata   = m.wdata;
        s_clint.wstrb   = m.wstrb;
        s_clint.awvalid = 1'b0;
        s_clint.wvalid  = 1'b0;
        s_clint.bready  = 1'b0;
        m.awready       = 1'b0;
        m.wready        = 1'b0;
        m.bvalid        = 1'b0;
        m.bresp         = 2'b00;
        case (wr_state)
            WR_IDLE: begin
                case (aw_dec)
                    SEL_SRAM:  begin s_sram.awvalid  = m.awvalid; m.awready = s_sram.awready;  end
                    SEL_UART:  begin s_uart.awvalid  = m.awvalid; m.awready = s_uart.awready;  end
                    SEL_CLINT: begin s_clint.awvalid = m.awvalid; m.awready = s_clint.awready; end
                    default:   m.awready = 1'b1;
                endcase
            end
            WR_DATA: begin
                case (wr_sel)
                    SEL_SRAM:  begin s_sram.wvalid  = m.wvalid; m.wready = s_sram.wready;  end
                    SEL_UART:  begin s_uart.wvalid  = m.wvalid; m.wready = s_uart.wready;  end
                    SEL_CLINT: begin s_clint.wvalid = m.wvalid; m.wready = s_clint.wready; end
                    default: ;
                endcase
            end
            WR_RESP: begin
                case (wr_sel)
                    SEL_SRAM: begin
                        m.bvalid = s_sram.bvalid; m.bresp = s_sram.bresp; s_sram.bready = m.bready;
                    end
                    SEL_UART: begin
                        m.bvalid = s_uart.bvalid; m.bresp = s_uart.bresp; s_uart.bready = m.bready;
                    end
                    SEL_CLINT: begin
                        m.bvalid = s_clint.bvalid; m.bresp = s_clint.bresp; s_clint.bready = m.bready;
                    end
                    default: ;
                endcase
            end
            WR_ERR_W: m.wready = 1'b1;
            WR_ERR_B: begin
                m.bvalid = 1'b1;
                m.bresp  = 2'b11;
            end
            default: ;
        endcase
    end

    // Write FSM: AW, then W, then B, against the latched target. Unmapped writes are absorbed locally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state <= WR_IDLE;
            wr_sel   <= SEL_NONE;
        end else begin
            case (wr_state)
                WR_IDLE: if (m.awvalid && m.awready) begin
                    wr_sel   <= aw_dec;
                    wr_state <= (aw_dec == SEL_NONE) ? WR_ERR_W : WR_DATA;
                end
                WR_DATA:  if (m.wvalid && m.wready) wr_state <= WR_RESP;
                WR_RESP: if (m.bvalid && m.bready) begin
                    wr_sel   <= SEL_NONE;
                    wr_state <= WR_IDLE;
                end
                WR_ERR_W: if (m.wvalid) wr_state <= WR_ERR_B;
                WR_ERR_B: if (m.bready) begin
                    wr_sel   <= SEL_NONE;
                    wr_state <= WR_IDLE;
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

`ifdef XBAR_DECERR_FATAL_EN
    // Stop the simulation on the first handshake to an unmapped address.
    always @(posedge clk) begin
        if (!reset && rd_state == RD_IDLE && m.arvalid && m.arready && ar_dec == SEL_NONE)
            $fatal(1, "axi_lite_xbar: read from unmapped address %h", m.araddr);
        if (!reset && wr_state == WR_IDLE && m.awvalid && m.awready && aw_dec == SEL_NONE)
            $fatal(1, "axi_lite_xbar: write to unmapped address %h", m.awaddr);
    end
`endif

endmodule
